// File: rtl/decoder_bist_pkg.sv
// Shared types and sizes for the decoder BIST sequencer.
package decoder_bist_pkg;

    localparam int SEL_W = 4;
    localparam int OUT_W = 1 << SEL_W;
    localparam int CNT_W = SEL_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

endpackage

// File: rtl/decoder_bist_ctrl_onehot_chk.sv
// Combinational shape check of one decoder output sample.
module onehot_chk
    import decoder_bist_pkg::*;
(
    input  logic [OUT_W-1:0] word,
    input  logic [SEL_W-1:0] exp_idx,
    output logic             is_onehot,
    output logic [SEL_W-1:0] idx,
    output logic             match
);

    logic [CNT_W-1:0] ones;

    // Count set bits and locate the lowest one; any X/Z makes the word invalid.
    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = OUT_W - 1; i >= 0; i--) begin
            if (word[i]) begin
                ones = ones + CNT_W'(1);
                idx  = SEL_W'(i);
            end
        end
        is_onehot = (ones == CNT_W'(1)) && ((^word) !== 1'bx);
        match     = (word === (OUT_W'(1) << exp_idx));
    end

endmodule

// File: rtl/decoder_bist_ctrl.sv
// BIST sequencer: walks every select code through an external decoder and
// grades the sampled outputs.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for start, results held
// ST_DRIVE  | dec_sel = code, settle timer loaded
// ST_WAIT   | settle timer counting down (skipped when SETTLE = 0)
// ST_SAMPLE | dec_out graded against 1 << code
// ST_FIN    | one-cycle done pulse, results valid
module decoder_bist_ctrl
    import decoder_bist_pkg::*;
#(
    parameter int SETTLE       = 1,     // 0..7
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [SEL_W-1:0] dec_sel,
    input  logic [OUT_W-1:0] dec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [SEL_W-1:0] first_fail_code,
    output logic [OUT_W-1:0] first_fail_obs,
    output logic [SEL_W-1:0] stuck0,
    output logic [SEL_W-1:0] stuck1,
    output logic             bad_shape
);

    localparam int SETTLE_M1 = (SETTLE > 0) ? SETTLE - 1 : 0;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       settle_cnt;
    logic             is_onehot;
    logic [SEL_W-1:0] obs_idx;
    logic             match;
    logic             mismatch;
    logic             last_code;

    onehot_chk u_chk (
        .word      (dec_out),
        .exp_idx   (dec_sel),
        .is_onehot (is_onehot),
        .idx       (obs_idx),
        .match     (match)
    );

    assign mismatch  = !match;
    assign last_code = (dec_sel == '1) || (STOP_ON_FAIL && mismatch);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                busy      = 1'b1;
                state_nxt = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (settle_cnt == 3'd0) state_nxt = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                busy      = 1'b1;
                state_nxt = last_code ? ST_FIN : ST_DRIVE;
            end
            ST_FIN: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Code counter, settle timer and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_sel         <= '0;
            settle_cnt      <= '0;
            pass            <= 1'b0;
            fail_cnt        <= '0;
            first_fail_code <= '0;
            first_fail_obs  <= '0;
            stuck0          <= '0;
            stuck1          <= '0;
            bad_shape       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dec_sel         <= '0;
                        pass            <= 1'b0;
                        fail_cnt        <= '0;
                        first_fail_code <= '0;
                        first_fail_obs  <= '0;
                        stuck0          <= '0;
                        stuck1          <= '0;
                        bad_shape       <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    settle_cnt <= 3'(SETTLE_M1);
                end
                ST_WAIT: begin
                    if (settle_cnt != 3'd0) settle_cnt <= settle_cnt - 3'd1;
                end
                ST_SAMPLE: begin
                    if (mismatch) begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
                        if (fail_cnt == '0) begin
                            first_fail_code <= dec_sel;
                            first_fail_obs  <= dec_out;
                        end
                        if (is_onehot) begin
                            stuck0 <= stuck0 | (dec_sel & ~obs_idx);
                            stuck1 <= stuck1 | (~dec_sel & obs_idx);
                        end else begin
                            bad_shape <= 1'b1;
                        end
                    end
                    // pass must already be valid in the FIN cycle
                    if (last_code) pass <= !mismatch && (fail_cnt == '0);
                    else           dec_sel <= dec_sel + SEL_W'(1);
                end
                ST_FIN: begin
                    dec_sel <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_bist_ctrl.sv
// Self-checking bench: three sequencer instances with different SETTLE /
// STOP_ON_FAIL settings, each driving a table-driven model decoder.
module tb_decoder_bist_ctrl;

    localparam int N_INST = 3;

    function automatic int settle_of(input int k);
        return (k == 2) ? 0 : 1;
    endfunction

    function automatic bit stop_of(input int k);
        return (k == 1);
    endfunction

    typedef struct {
        int inst;
        int mode;
        bit pass;
        int fcnt;
        int ffc;
        int ffo;
        int s0;
        int s1;
        bit bad;
        int busy_cyc;
        bit extra;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_v [N_INST];
    logic [3:0]  sel_v   [N_INST];
    logic [15:0] dout_v  [N_INST];
    logic        busy_v  [N_INST];
    logic        done_v  [N_INST];
    logic        pass_v  [N_INST];
    logic [4:0]  fcnt_v  [N_INST];
    logic [3:0]  ffc_v   [N_INST];
    logic [15:0] ffo_v   [N_INST];
    logic [3:0]  s0_v    [N_INST];
    logic [3:0]  s1_v    [N_INST];
    logic        bad_v   [N_INST];

    logic [15:0] fault_tab [16];
    int          done_cnt  [N_INST];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N_INST; g++) begin : g_dut
        assign dout_v[g] = fault_tab[sel_v[g]];
        decoder_bist_ctrl #(
            .SETTLE       (settle_of(g)),
            .STOP_ON_FAIL (stop_of(g))
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .start           (start_v[g]),
            .dec_sel         (sel_v[g]),
            .dec_out         (dout_v[g]),
            .busy            (busy_v[g]),
            .done            (done_v[g]),
            .pass            (pass_v[g]),
            .fail_cnt        (fcnt_v[g]),
            .first_fail_code (ffc_v[g]),
            .first_fail_obs  (ffo_v[g]),
            .stuck0          (s0_v[g]),
            .stuck1          (s1_v[g]),
            .bad_shape       (bad_v[g])
        );
    end

    always @(negedge clk) begin
        for (int k = 0; k < N_INST; k++)
            if (done_v[k] === 1'b1) done_cnt[k] <= done_cnt[k] + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] res_pack(input int k);
        return 64'({pass_v[k], fcnt_v[k], ffc_v[k], ffo_v[k], s0_v[k], s1_v[k], bad_v[k]});
    endfunction

    function automatic logic [63:0] all_pack(input int k);
        return 64'({busy_v[k], done_v[k], sel_v[k], res_pack(k)[34:0]});
    endfunction

    task automatic set_mode(input int m);
        for (int c = 0; c < 16; c++) begin
            case (m)
                1:       fault_tab[c] = 16'(1) << (c & 4'b1011);
                2:       fault_tab[c] = (c == 9) ? 16'h0003 : (16'(1) << c);
                default: fault_tab[c] = 16'(1) << c;
            endcase
        end
    endtask

    // Reference grading of the current fault table, straight from the scan rules.
    task automatic model(input int k, output vec_t v);
        int n;
        logic [15:0] w;
        logic [3:0] j;
        v = '{inst: k, mode: -1, pass: 0, fcnt: 0, ffc: 0, ffo: 0, s0: 0, s1: 0,
              bad: 0, busy_cyc: 0, extra: 0};
        n = 0;
        for (int c = 0; c < 16; c++) begin
            n++;
            w = fault_tab[c];
            if (w != (16'(1) << c)) begin
                v.fcnt++;
                if (v.fcnt == 1) begin
                    v.ffc = c;
                    v.ffo = int'(w);
                end
                if ($countones(w) == 1) begin
                    j    = 4'($clog2(w));
                    v.s0 = v.s0 | (c & ~int'(j) & 15);
                    v.s1 = v.s1 | (~c & int'(j) & 15);
                end else begin
                    v.bad = 1'b1;
                end
                if (stop_of(k)) break;
            end
        end
        v.pass     = (v.fcnt == 0);
        v.busy_cyc = n * (settle_of(k) + 2);
    endtask

    task automatic run_scan(input vec_t v, input string tag);
        int k, cyc, d0;
        k = v.inst;
        @(negedge clk);
        d0 = done_cnt[k];
        start_v[k] = 1'b1;
        @(negedge clk);
        start_v[k] = 1'b0;
        check($sformatf("%s busy_rise", tag), 64'(busy_v[k]), 64'd1);
        check($sformatf("%s cleared", tag), res_pack(k), 64'd0);
        cyc = 0;
        while (busy_v[k] === 1'b1 && cyc < 2000) begin
            cyc++;
            start_v[k] = v.extra && (cyc == 5 || cyc == 20);
            @(negedge clk);
        end
        start_v[k] = 1'b0;
        check($sformatf("%s busy_cycles", tag), 64'(cyc), 64'(v.busy_cyc));
        check($sformatf("%s done", tag), 64'(done_v[k]), 64'd1);
        check($sformatf("%s pass", tag), 64'(pass_v[k]), 64'(v.pass));
        check($sformatf("%s fail_cnt", tag), 64'(fcnt_v[k]), 64'(v.fcnt));
        check($sformatf("%s first_code", tag), 64'(ffc_v[k]), 64'(v.ffc));
        check($sformatf("%s first_obs", tag), 64'(ffo_v[k]), 64'(v.ffo));
        check($sformatf("%s stuck0", tag), 64'(s0_v[k]), 64'(v.s0));
        check($sformatf("%s stuck1", tag), 64'(s1_v[k]), 64'(v.s1));
        check($sformatf("%s bad_shape", tag), 64'(bad_v[k]), 64'(v.bad));
        if (v.extra) start_v[k] = 1'b1;   // coincident with FIN
        @(negedge clk);
        start_v[k] = 1'b0;
        check($sformatf("%s idle_after_fin", tag), 64'({busy_v[k], done_v[k], sel_v[k]}), 64'd0);
        repeat (3) @(negedge clk);
        check($sformatf("%s stays_idle", tag), 64'(busy_v[k]), 64'd0);
        check($sformatf("%s done_pulses", tag), 64'(done_cnt[k] - d0), 64'd1);
        check($sformatf("%s results_hold", tag), 64'(fcnt_v[k]), 64'(v.fcnt));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vec_t rv;
        int cyc, d0;

        vecs[0] = '{0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 48, 0};
        vecs[1] = '{0, 1, 0, 8, 4, 16'h0001, 4, 0, 0, 48, 0};
        vecs[2] = '{1, 1, 0, 1, 4, 16'h0001, 4, 0, 0, 15, 0};
        vecs[3] = '{0, 2, 0, 1, 9, 16'h0003, 0, 0, 1, 48, 0};
        vecs[4] = '{2, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 32, 0};
        vecs[5] = '{2, 1, 0, 8, 4, 16'h0001, 4, 0, 0, 32, 0};
        vecs[6] = '{1, 2, 0, 1, 9, 16'h0003, 0, 0, 1, 30, 0};
        vecs[7] = '{0, 0, 1, 0, 0, 16'h0000, 0, 0, 0, 48, 1};

        for (int k = 0; k < N_INST; k++) begin
            start_v[k]  = 1'b0;
            done_cnt[k] = 0;
        end
        set_mode(0);
        repeat (3) @(negedge clk);
        for (int k = 0; k < N_INST; k++)
            check($sformatf("reset_state i%0d", k), all_pack(k), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            set_mode(vecs[i].mode);
            run_scan(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the WAIT cycle of code 6 aborts silently.
        set_mode(0);
        @(negedge clk);
        d0 = done_cnt[0];
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        cyc = 0;
        while (sel_v[0] !== 4'd6 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        check("reach_code6", 64'(sel_v[0]), 64'd6);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midscan_reset_outputs", all_pack(0), 64'd0);
        repeat (4) @(negedge clk);
        check("midscan_reset_no_done", 64'(done_cnt[0] - d0), 64'd0);
        rst = 1'b0;
        run_scan(vecs[0], "post_reset");

        // Randomized fault tables against the reference model.
        for (int it = 0; it < 24; it++) begin
            for (int c = 0; c < 16; c++) begin
                case ($urandom_range(0, 3))
                    0, 1:    fault_tab[c] = 16'(1) << c;
                    2:       fault_tab[c] = 16'(1) << $urandom_range(0, 15);
                    default: fault_tab[c] = 16'($urandom);
                endcase
            end
            model(int'($urandom_range(0, N_INST - 1)), rv);
            rv.extra = 1'($urandom_range(0, 1));
            run_scan(rv, $sformatf("rnd%0d i%0d", it, rv.inst));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
